universal_shift_reg: RTL
========================

# universal_shift_reg

Parametrised universal shift register, the next-generation replacement for the fixed 4-bit parallel-in/parallel-out register. It adds width parametrisation, serial-in/serial-out in both directions, an explicit mode select, a clock enable, and a shift counter with a completion pulse. It is intended as the common storage and serialisation element for parallel-to-serial and serial-to-parallel paths.

## Interface
- WIDTH, 4, register width in bits; legal range 2..64
- RESET_VAL, '0, WIDTH-bit value loaded into po on reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  clock enable; 0 = all state holds
- mode  input  2  operation select: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD
- pi  input  WIDTH  parallel data in
- sin_r  input  1  serial in for SHR; enters at po[WIDTH-1]
- sin_l  input  1  serial in for SHL; enters at po[0]
- rot  input  1  rotate select; present only with USR_ROTATE_EN
- po  output  WIDTH  parallel data out (register contents)
- sout_r  output  1  po[0]; the bit leaving on SHR
- sout_l  output  1  po[WIDTH-1]; the bit leaving on SHL
- shift_cnt  output  $clog2(WIDTH+1)  shifts since last LOAD, saturating at WIDTH
- done  output  1  one-cycle pulse when shift_cnt reaches WIDTH

## Operation
- Reset asserted (reset=0), asynchronous: po=RESET_VAL, shift_cnt=0, done=0. Held while reset=0; takes effect immediately, including mid-shift.
- en=0: po and shift_cnt hold; done=0 on the next edge.
- en=1, per rising edge, by mode:
  - HOLD: po holds; shift_cnt holds; done=0.
  - SHR: po <= {sin_r, po[WIDTH-1:1]}.
  - SHL: po <= {po[WIDTH-2:0], sin_l}.
  - LOAD: po <= pi; shift_cnt <= 0; done <= 0.
- Counter: each SHR or SHL with shift_cnt<WIDTH increments shift_cnt. The transition to WIDTH registers done=1 for exactly that one cycle. At WIDTH, shifts continue to move data, but shift_cnt stays at WIDTH and done stays 0.
- SHR and SHL both count toward the same shift_cnt; direction changes do not reset it.
- sout_r and sout_l are combinational taps of the register, with no additional logic.

## Timing
- po, shift_cnt and done change only on a rising clk edge or on reset assertion.
- LOAD latency: pi is visible on po one edge after LOAD is sampled.
- Serial latency: a bit on sin_r appears on sout_r after WIDTH SHR edges.
- done rises on the same edge that makes shift_cnt==WIDTH and falls on the next edge.
- Reset release is synchronous to clk in the surrounding design. The first functional edge is the first edge with reset=1.

## Configuration
- USR_ROTATE_EN defined:
  - The rot port exists.
  - SHR with rot=1 gives po <= {po[0], po[WIDTH-1:1]}, and sin_r is ignored.
  - SHL with rot=1 gives po <= {po[WIDTH-2:0], po[WIDTH-1]}, and sin_l is ignored.
  - Rotates count toward shift_cnt and done like shifts.
- USR_ROTATE_EN undefined: the rot port is absent, and all shifts are fill-from-serial-in.

## Structure
- Package usr_pkg:
  - typedef enum logic [1:0] usr_mode_t {USR_HOLD, USR_SHR, USR_SHL, USR_LOAD}
  - localparam for the default WIDTH
- Sub-module usr_shift_counter: owns shift_cnt and done.
  - Parameter WIDTH.
  - Inputs: clk, reset, en, shift (1 on SHR/SHL), load.
- Top level holds the data register, the mode decode and the serial taps.

## Test plan
- Reset: hold reset=0 with pi=4'b1000 and mode=LOAD -> po=0000, shift_cnt=0, done=0. Release, LOAD one edge -> po=1000.
- Shift right: po=1000, mode=SHR, sin_r=0, one edge -> po=0100, sout_r=0, shift_cnt=1. A second edge with sin_r=1 -> po=1010.
- Fill and done: from LOAD 0000, SHL with sin_l=1 for 4 edges -> po=1111, shift_cnt=4, done=1 on edge 4 only. A 5th SHL -> shift_cnt=4, done=0.
- Enable/hold: po=0010, en=0 with mode=SHL for 3 edges -> po=0010, shift_cnt unchanged. en=1, mode=HOLD, pi=1111 -> po=0010.
- Async reset mid-operation: after 2 SHL edges, drop reset between edges -> po=0000 and shift_cnt=0 immediately, without a clock edge. LOAD 1111 after release -> po=1111.
- USR_ROTATE_EN: po=0001, SHR with rot=1 -> 1000. Then SHL with rot=1 -> 0001. done pulses after 4 rotates following a LOAD.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and defaults for the universal shift register.
// Optional rotate support is enabled with the USR_ROTATE_EN macro.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_t;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/usr_shift_counter.sv
// Counts shifts since the last LOAD and saturates at WIDTH.
// Emits a one-cycle done pulse when the count reaches WIDTH.
module usr_shift_counter #(
    parameter int WIDTH = usr_pkg::USR_DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       shift,
    input  logic                       load,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_inc;
    assign cnt_inc = shift_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else if (load) begin
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (shift && (shift_cnt < CNT_MAX)) begin
            shift_cnt <= cnt_inc;
            done      <= (cnt_inc == CNT_MAX);
        end else begin
            // Saturated shifts and HOLD both drop the pulse.
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load.
// Define USR_ROTATE_EN to add the rot port and rotate-in-place shifts.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = USR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           pi,
    input  logic                       sin_r,
    input  logic                       sin_l,
`ifdef USR_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           po,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    usr_mode_t        mode_e;
    logic [WIDTH-1:0] po_q;
    logic [WIDTH-1:0] po_nxt;
    logic             fill_r;
    logic             fill_l;
    logic             shift;
    logic             load;

    assign mode_e = usr_mode_t'(mode);
    assign shift  = (mode_e == USR_SHR) || (mode_e == USR_SHL);
    assign load   = (mode_e == USR_LOAD);

`ifdef USR_ROTATE_EN
    // Rotation feeds the departing bit back in at the opposite end.
    assign fill_r = rot ? po_q[0]       : sin_r;
    assign fill_l = rot ? po_q[WIDTH-1] : sin_l;
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif

    always_comb begin
        po_nxt = po_q;
        case (mode_e)
            USR_SHR:  po_nxt = {fill_r, po_q[WIDTH-1:1]};
            USR_SHL:  po_nxt = {po_q[WIDTH-2:0], fill_l};
            USR_LOAD: po_nxt = pi;
            default:  po_nxt = po_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  po_q <= RESET_VAL;
        else if (en) po_q <= po_nxt;
    end

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .shift     (shift),
        .load      (load),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    assign po     = po_q;
    assign sout_r = po_q[0];
    assign sout_l = po_q[WIDTH-1];

endmodule
